// File: rtl/sprite_ram_loader_if.sv
// Loader and VGA read-side signal bundle for sprite_ram_loader.
// rd_mirror exists only when SPRITE_LOADER_MIRROR_EN is defined.
interface sprite_ram_loader_if #(
   parameter int WORD_W   = 16,
   parameter int PIX_BITS = 2
);
   logic                clear_req;
   logic                load_start;
   logic                wr_valid;
   logic [WORD_W-1:0]   wr_data;
   logic                wr_ready;
   logic                busy;
   logic                load_done;
   logic [9:0]          rd_horz;
   logic [9:0]          rd_vert;
   logic [PIX_BITS-1:0] rd_pixel;
`ifdef SPRITE_LOADER_MIRROR_EN
   logic                rd_mirror;

   modport master (
      output clear_req, load_start, wr_valid, wr_data, rd_horz, rd_vert, rd_mirror,
      input  wr_ready, busy, load_done, rd_pixel
   );
   modport slave (
      input  clear_req, load_start, wr_valid, wr_data, rd_horz, rd_vert, rd_mirror,
      output wr_ready, busy, load_done, rd_pixel
   );
`else
   modport master (
      output clear_req, load_start, wr_valid, wr_data, rd_horz, rd_vert,
      input  wr_ready, busy, load_done, rd_pixel
   );
   modport slave (
      input  clear_req, load_start, wr_valid, wr_data, rd_horz, rd_vert,
      output wr_ready, busy, load_done, rd_pixel
   );
`endif
endinterface

// File: rtl/sprite_ram_loader.sv
// Run-time writable 2bpp sprite store: clear/load FSM on the write side, registered pixel read.
// Optional horizontal flip on reads when SPRITE_LOADER_MIRROR_EN is defined.
module sprite_ram_loader #(
   parameter int SPRITE_W = 32,
   parameter int SPRITE_H = 32,
   parameter int PIX_BITS = 2,
   parameter int WORD_PIX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   sprite_ram_loader_if.slave bus
);

   localparam int WORDS_PER_ROW = SPRITE_W / WORD_PIX;
   localparam int DEPTH         = WORDS_PER_ROW * SPRITE_H;
   localparam int ADDR_W        = $clog2(DEPTH);
   localparam int COL_W         = $clog2(SPRITE_W);
   localparam int SEL_W         = $clog2(WORD_PIX);
   localparam int ROW_W         = $clog2(SPRITE_H);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
   localparam logic [9:0]        H_LIMIT   = 10'(SPRITE_W);
   localparam logic [9:0]        V_LIMIT   = 10'(SPRITE_H);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_LOAD
   } state_e;

   typedef logic [WORD_PIX-1:0][PIX_BITS-1:0] word_t;

   word_t mem [DEPTH];

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                mem_we;
   word_t               mem_wdata;

   logic [COL_W-1:0]    rd_col;
   logic [ADDR_W-1:0]   rd_addr;
   logic [SEL_W-1:0]    rd_sel;
   logic                rd_in_range;
   logic [PIX_BITS-1:0] pix_q;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;

      unique case (state_q)
         S_CLEAR: begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (bus.clear_req) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end else if (bus.load_start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            // Abort and restart both drop any handshake offered in the same cycle.
            if (bus.clear_req) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end else if (bus.load_start) begin
               cnt_d = '0;
            end else if (bus.wr_valid) begin
               mem_we    = 1'b1;
               mem_wdata = word_t'(bus.wr_data);
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == LAST_WORD) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // NOTE: the pixel array has no reset; the automatic clear after reset gives it known contents.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[cnt_q] <= mem_wdata;
      end
   end

`ifdef SPRITE_LOADER_MIRROR_EN
   // For a power-of-two width, inverting the column bits gives SPRITE_W-1-col.
   assign rd_col = bus.rd_mirror ? ~bus.rd_horz[COL_W-1:0] : bus.rd_horz[COL_W-1:0];
`else
   assign rd_col = bus.rd_horz[COL_W-1:0];
`endif

   assign rd_in_range = (bus.rd_horz < H_LIMIT) && (bus.rd_vert < V_LIMIT);
   assign rd_addr     = {bus.rd_vert[ROW_W-1:0], rd_col[COL_W-1:SEL_W]};
   assign rd_sel      = rd_col[SEL_W-1:0];

   // Reading the array before the write lands returns the old word on a same-cycle collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q <= '0;
      end else if (rd_in_range) begin
         pix_q <= mem[rd_addr][rd_sel];
      end else begin
         pix_q <= '0;
      end
   end

   assign bus.wr_ready  = (state_q == S_LOAD);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.load_done = done_q;
   assign bus.rd_pixel  = pix_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed self-checking bench for sprite_ram_loader: clear, load, backpressure, abort, bounds.
// Mirror reads are exercised when SPRITE_LOADER_MIRROR_EN is defined.
`timescale 1ns/1ps
module tb_sprite_ram_loader;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   sprite_ram_loader_if bus ();

   sprite_ram_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] gen_word(input int i);
      logic [6:0] a;
      a = 7'(i);
      return {a, 2'b10, ~a};
   endfunction

   function automatic logic [15:0] word_for(input int kind, input int i);
      case (kind)
         0:       return 16'hE4E4;
         1:       return gen_word(i);
         2:       return 16'hFFFF;
         default: return (i == 0) ? 16'hC000 : 16'h0000;
      endcase
   endfunction

   // Present coordinates at a falling edge, return the pixel registered at the next rising edge.
   task automatic rd(input int h, input int v, output logic [1:0] px);
      bus.rd_horz = 10'(h);
      bus.rd_vert = 10'(v);
      @(negedge clk);
      px = bus.rd_pixel;
   endtask

   // Full 128-word load; kind selects the data pattern, gap_mod > 0 drops wr_valid every gap_mod cycles.
   task automatic load_run(input string name, input int kind, input int gap_mod);
      int hs;
      int k;
      bit early;
      hs = 0;
      k = 0;
      early = 1'b0;
      @(negedge clk);
      bus.load_start = 1'b1;
      @(negedge clk);
      bus.load_start = 1'b0;
      while (hs < 128 && k < 2000) begin
         bus.wr_valid = (gap_mod == 0) || ((k % gap_mod) != 0);
         bus.wr_data  = bus.wr_valid ? word_for(kind, hs) : 16'hDEAD;
         if (bus.load_done) early = 1'b1;
         if (bus.wr_valid && bus.wr_ready) hs++;
         k++;
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      n_checks++;
      if (hs !== 128 || early) begin
         n_errors++;
         $display("FAIL %s handshakes: got %0d early_done=%0d, expected 128 early_done=0", name, hs, early);
      end
      n_checks++;
      if (bus.load_done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL %s done_cycle: load_done=%b busy=%b wr_ready=%b, expected 1 0 0",
                  name, bus.load_done, bus.busy, bus.wr_ready);
      end
      @(negedge clk);
      n_checks++;
      if (bus.load_done !== 1'b0) begin
         n_errors++;
         $display("FAIL %s done_pulse_width: load_done=%b one cycle later, expected 0", name, bus.load_done);
      end
   endtask

   task automatic test_reset();
      int cyc;
      logic [1:0] px;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.load_done !== 1'b0 || bus.rd_pixel !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_outputs: busy=%b wr_ready=%b load_done=%b rd_pixel=%b, expected 1 0 0 00",
                  bus.busy, bus.wr_ready, bus.load_done, bus.rd_pixel);
      end
      rst_n = 1'b1;
      cyc = 0;
      while (bus.busy && cyc < 300) begin
         cyc++;
         @(negedge clk);
      end
      n_checks++;
      if (cyc !== 128) begin
         n_errors++;
         $display("FAIL reset_clear_len: busy for %0d cycles, expected 128", cyc);
      end
      n_checks++;
      if (bus.wr_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_idle_ready: wr_ready=%b, expected 0", bus.wr_ready);
      end
      rd(5, 5, px);
      n_checks++;
      if (px !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_read: rd_pixel=%b, expected 00", px);
      end
   endtask

   task automatic test_full_load();
      int hv [4][2] = '{'{0, 0}, '{1, 0}, '{2, 7}, '{31, 31}};
      logic [1:0] exp [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [1:0] px;
      load_run("full_load", 0, 0);
      for (int i = 0; i < 4; i++) begin
         rd(hv[i][0], hv[i][1], px);
         n_checks++;
         if (px !== exp[i]) begin
            n_errors++;
            $display("FAIL full_load_read(%0d,%0d): rd_pixel=%b, expected %b", hv[i][0], hv[i][1], px, exp[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int words [6] = '{0, 1, 2, 3, 63, 127};
      int pixs  [3] = '{0, 3, 7};
      bit ready_seen;
      logic [15:0] d;
      logic [1:0] exp;
      logic [1:0] px;
      load_run("backpressure", 1, 3);
      ready_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = 16'(16'h1111 * i);
         if (bus.wr_ready) ready_seen = 1'b1;
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      n_checks++;
      if (ready_seen) begin
         n_errors++;
         $display("FAIL idle_wr_ready: wr_ready=1 seen in IDLE, expected 0");
      end
      for (int w = 0; w < 6; w++) begin
         for (int p = 0; p < 3; p++) begin
            d   = gen_word(words[w]);
            exp = d[2*pixs[p] +: 2];
            rd((words[w] % 4) * 8 + pixs[p], words[w] / 4, px);
            n_checks++;
            if (px !== exp) begin
               n_errors++;
               $display("FAIL backpressure_read word %0d pix %0d: rd_pixel=%b, expected %b",
                        words[w], pixs[p], px, exp);
            end
         end
      end
   endtask

   task automatic test_abort();
      int hs;
      int k;
      int cyc;
      int bad;
      bit done_seen;
      logic [1:0] px;
      hs = 0;
      k = 0;
      done_seen = 1'b0;
      @(negedge clk);
      bus.load_start = 1'b1;
      @(negedge clk);
      bus.load_start = 1'b0;
      bus.wr_valid   = 1'b1;
      bus.wr_data    = 16'hFFFF;
      while (hs < 40 && k < 500) begin
         if (bus.wr_ready) hs++;
         k++;
         @(negedge clk);
      end
      bus.clear_req = 1'b1;
      @(negedge clk);
      bus.clear_req = 1'b0;
      bus.wr_valid  = 1'b0;
      cyc = 0;
      while (bus.busy && cyc < 300) begin
         if (bus.load_done) done_seen = 1'b1;
         cyc++;
         @(negedge clk);
      end
      if (bus.load_done) done_seen = 1'b1;
      n_checks++;
      if (cyc !== 128 || done_seen) begin
         n_errors++;
         $display("FAIL abort_clear: busy %0d cycles load_done_seen=%0d, expected 128 and 0", cyc, done_seen);
      end
      bad = 0;
      for (int v = 0; v < 32; v++) begin
         for (int h = 0; h < 32; h++) begin
            rd(h, v, px);
            if (px !== 2'b00) bad++;
         end
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL abort_sweep: %0d nonzero pixels, expected 0", bad);
      end
   endtask

   task automatic test_bounds_priority();
      int hv [5][2] = '{'{0, 0}, '{31, 31}, '{32, 0}, '{0, 32}, '{639, 479}};
      logic [1:0] exp [5] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
      logic [1:0] px;
      int cyc;
      load_run("bounds_fill", 2, 0);
      for (int i = 0; i < 5; i++) begin
         rd(hv[i][0], hv[i][1], px);
         n_checks++;
         if (px !== exp[i]) begin
            n_errors++;
            $display("FAIL bounds_read(%0d,%0d): rd_pixel=%b, expected %b", hv[i][0], hv[i][1], px, exp[i]);
         end
      end
      bus.clear_req  = 1'b1;
      bus.load_start = 1'b1;
      @(negedge clk);
      bus.clear_req  = 1'b0;
      bus.load_start = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL priority_state: busy=%b wr_ready=%b, expected 1 0 (CLEAR)", bus.busy, bus.wr_ready);
      end
      cyc = 0;
      while (bus.busy && cyc < 300) begin
         cyc++;
         @(negedge clk);
      end
      rd(0, 0, px);
      n_checks++;
      if (cyc !== 128 || px !== 2'b00) begin
         n_errors++;
         $display("FAIL priority_clear: busy %0d cycles rd_pixel=%b, expected 128 and 00", cyc, px);
      end
   endtask

`ifdef SPRITE_LOADER_MIRROR_EN
   task automatic test_mirror();
      int  h   [4] = '{7, 24, 7, 32};
      bit  m   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [1:0] exp [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
      logic [1:0] px;
      load_run("mirror_load", 3, 0);
      for (int i = 0; i < 4; i++) begin
         bus.rd_mirror = m[i];
         rd(h[i], 0, px);
         n_checks++;
         if (px !== exp[i]) begin
            n_errors++;
            $display("FAIL mirror_read(%0d,0,m=%0d): rd_pixel=%b, expected %b", h[i], m[i], px, exp[i]);
         end
      end
      bus.rd_mirror = 1'b0;
   endtask
`endif

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst_n          = 1'b0;
      bus.clear_req  = 1'b0;
      bus.load_start = 1'b0;
      bus.wr_valid   = 1'b0;
      bus.wr_data    = '0;
      bus.rd_horz    = '0;
      bus.rd_vert    = '0;
`ifdef SPRITE_LOADER_MIRROR_EN
      bus.rd_mirror  = 1'b0;
`endif
      test_reset();
      test_full_load();
      test_backpressure();
      test_abort();
      test_bounds_priority();
`ifdef SPRITE_LOADER_MIRROR_EN
      test_mirror();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
- Writable 32x32, 2-bit-per-pixel sprite store for the VGA sprite path.
- Write side: a loader feeds packed pixel words through a valid/ready handshake.
- Read side: the VGA draw logic presents sprite-relative horz/vert and receives a 2-bit colour index. Index 00 is transparent.
- Lets sprites be replaced at run time instead of being fixed at synthesis.

Parameters:
- SPRITE_W, 32, sprite width in pixels (multiple of WORD_PIX)
- SPRITE_H, 32, sprite height in pixels
- PIX_BITS, 2, bits per pixel colour index
- WORD_PIX, 8, pixels per write word (write word width = WORD_PIX*PIX_BITS = 16)

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- clear_req  in  1  one-cycle request: fill whole sprite with 00
- load_start  in  1  one-cycle request: begin a full-sprite load at word 0
- wr_valid  in  1  write word valid
- wr_data  in  16  eight pixels; [1:0] is the leftmost pixel, [15:14] the rightmost
- wr_ready  out  1  block accepts wr_data this cycle
- busy  out  1  clear or load in progress
- load_done  out  1  one-cycle pulse when a full load completes
- rd_horz  in  10  sprite-relative column
- rd_vert  in  10  sprite-relative row
- rd_pixel  out  2  colour index at (rd_horz, rd_vert)

Behaviour:
- Storage: 128 words x 16 bits. Word index = row*4 + col/8. Pixel p of a word = bits [2p+1:2p].
- Word counter: 7 bits, range 0..127.
- States: CLEAR, IDLE, LOAD.
- Reset (rst_n low):
  - state=CLEAR, counter=0, busy=1, wr_ready=0, load_done=0, rd_pixel=00.
  - RAM contents are not reset directly; the automatic CLEAR provides known contents.
- CLEAR:
  - Writes 16'h0000 to word[counter] each cycle, counter+1.
  - After word 127 is written: state=IDLE and busy=0 on the next cycle. Total 128 cycles.
  - clear_req and load_start are ignored in CLEAR.
- IDLE:
  - busy=0, wr_ready=0.
  - clear_req -> CLEAR, counter=0.
  - Otherwise load_start -> LOAD, counter=0.
  - clear_req wins if both requests are high in the same cycle.
- LOAD:
  - busy=1, wr_ready=1.
  - Handshake = wr_valid & wr_ready. On handshake, word[counter] <= wr_data at that clock edge and counter+1. No write without a handshake.
  - On the handshake at counter=127: next cycle state=IDLE, busy=0, wr_ready=0, load_done=1 for exactly one cycle.
  - clear_req in LOAD aborts the load: no load_done, state=CLEAR, counter=0, and any handshake in that same cycle is discarded.
  - load_start in LOAD (without clear_req) restarts the load: counter=0, and any handshake in that same cycle is discarded.
- Read port:
  - Registered, 1-cycle latency: rd_pixel at cycle n+1 reflects coordinates at cycle n.
  - rd_horz >= SPRITE_W or rd_vert >= SPRITE_H returns 00.
  - Read of a word being written in the same cycle returns the old data; the new data is visible one cycle later.
  - The read port is active in every state; reads during CLEAR or LOAD return current RAM contents.
- Width rules:
  - Column word select = rd_horz[4:3].
  - Pixel select = rd_horz[2:0].
  - Row = rd_vert[4:0]; the range check uses the full 10 bits.

Optional Feature:
- Macro SPRITE_LOADER_MIRROR_EN.
- When defined:
  - Adds input port rd_mirror (1 bit).
  - When rd_mirror=1, the effective column = SPRITE_W-1-rd_horz (horizontal flip for facing direction).
  - The out-of-range check is applied to the unmirrored rd_horz.
  - Latency is unchanged.
- When undefined: no rd_mirror port; reads are unmirrored.

Test Plan:
1. Reset release -> busy=1 for exactly 128 cycles, then busy=0 and wr_ready=0; read (5,5) -> rd_pixel=00 one cycle later.
2. Full load:
   - Stimulus: load_start, then 128 words of 16'hE4E4 with wr_valid held high.
   - Cycle after the 128th handshake: load_done=1 for one cycle, busy=0.
   - Reads: (0,0)->00, (1,0)->01, (2,7)->10, (31,31)->11.
3. Backpressure: random wr_valid gaps -> only valid&ready cycles advance the counter, load_done after exactly 128 handshakes; in IDLE wr_ready=0 and wr_data changes leave RAM unchanged.
4. Abort: clear_req after 40 accepted words -> no load_done, busy stays 1 for 128 more cycles; every coordinate then reads 00.
5. Bounds and priority:
   - Reads (32,0), (0,32), (639,479) -> 00.
   - clear_req and load_start together in IDLE -> CLEAR, not LOAD.
6. Mirror (macro defined): after loading word 0 = 16'hC000 (pixel 7=11), read (7,0) with rd_mirror=0 -> 11; read (24,0) with rd_mirror=1 -> 11; read (7,0) with rd_mirror=1 -> 00.
